// File: rtl/seq11_pkg.sv
// Shared types and helpers for the time-shared "11" sequence detector.
// Holds the per-channel context encoding and the round-robin pointer wrap.
package seq11_pkg;

    typedef enum logic {
        ZERO = 1'b0,
        ONE  = 1'b1
    } ctx_t;

    localparam int CNT_W_DEF = 16;

    // Widest supported match counter; narrower counters take the low bits.
    localparam int CNT_W_MAX = 32;
    localparam logic [CNT_W_MAX-1:0] CNT_MAX = '1;

    function automatic int next_ptr(input int last, input int n);
        return (last + 1 >= n) ? 0 : last + 1;
    endfunction

endpackage

// File: rtl/seq11_detect_scheduler_if.sv
// Bundle of per-channel serial requests, grants, controls and the match event
// that connects the detector scheduler to its sources and downstream logic.
interface seq11_detect_scheduler_if
    import seq11_pkg::*;
#(
    parameter int N     = 4,
    parameter int CH_W  = 2,
    parameter int CNT_W = CNT_W_DEF
);
    logic [N-1:0]     bit_valid;
    logic [N-1:0]     bit_in;
    logic [N-1:0]     bit_ready;
    logic [N-1:0]     ch_en;
    logic [N-1:0]     clr_ch;
    logic             match_valid;
    logic [CH_W-1:0]  match_ch;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output bit_valid, bit_in, ch_en, clr_ch,
        input  bit_ready, match_valid, match_ch, match_cnt
    );

    modport slave (
        input  bit_valid, bit_in, ch_en, clr_ch,
        output bit_ready, match_valid, match_ch, match_cnt
    );

endinterface

// File: rtl/seq11_core.sv
// Combinational Mealy "11" detector step: given the saved context of one
// channel and its incoming bit, produce the next context and the match flag.
module seq11_core
    import seq11_pkg::*;
(
    input  ctx_t state,
    input  logic bit_in,
    output ctx_t next_state,
    output logic match
);

    always_comb begin
        next_state = ZERO;
        match      = 1'b0;
        case (state)
            ZERO: next_state = bit_in ? ONE : ZERO;
            ONE: begin
                next_state = bit_in ? ONE : ZERO;
                match      = bit_in;
            end
            default: next_state = ZERO;
        endcase
    end

endmodule

// File: rtl/seq11_detect_scheduler.sv
// Round-robin scheduler sharing one "11" detector core among N serial streams,
// each with its own saved context, producing one registered match per cycle.
module seq11_detect_scheduler
    import seq11_pkg::*;
#(
    parameter int N     = 4,
    parameter int CH_W  = 2,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    seq11_detect_scheduler_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_SAT = CNT_MAX[CNT_W-1:0];

    ctx_t             ctx_q [N];
    logic [N-1:0]     eligible;
    logic [N-1:0]     grant_oh;
    logic [CH_W-1:0]  last_grant;
    logic [CH_W-1:0]  grant_idx;
    logic             grant_hit;
    logic             match_fire;
    ctx_t             core_next;
    logic             core_match;
    int               scan_pos;

    assign eligible = bus.bit_valid & bus.ch_en;

    // Walk the channels once, starting just after the previous winner.
    always_comb begin
        grant_hit = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        scan_pos  = next_ptr(int'(last_grant), N);
        for (int i = 0; i < N; i++) begin
            if (!grant_hit && eligible[scan_pos[CH_W-1:0]]) begin
                grant_hit = 1'b1;
                grant_idx = scan_pos[CH_W-1:0];
            end
            scan_pos = next_ptr(scan_pos, N);
        end
        if (grant_hit) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    // Grants are withheld while reset is held, even though the scan is live.
    assign bus.bit_ready = grant_oh & {N{reset_n}};

    seq11_core u_core (
        .state      (ctx_q[grant_idx]),
        .bit_in     (bus.bit_in[grant_idx]),
        .next_state (core_next),
        .match      (core_match)
    );

    // A clear landing on the granted channel consumes the bit but suppresses the match.
    assign match_fire = grant_hit & core_match & ~bus.clr_ch[grant_idx];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                ctx_q[i] <= ZERO;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!bus.ch_en[i] || bus.clr_ch[i]) begin
                    ctx_q[i] <= ZERO;
                end else if (grant_hit && grant_idx == CH_W'(i)) begin
                    ctx_q[i] <= core_next;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= CH_W'(N - 1);
        end else if (grant_hit) begin
            last_grant <= grant_idx;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.match_valid <= 1'b0;
            bus.match_ch    <= '0;
            bus.match_cnt   <= '0;
        end else begin
            bus.match_valid <= match_fire;
            if (match_fire) begin
                bus.match_ch <= grant_idx;
                if (bus.match_cnt != CNT_SAT) begin
                    bus.match_cnt <= bus.match_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq11_detect_scheduler.sv
// Directed bench for the 4-channel detector scheduler with a 4-bit counter
// so that saturation is reachable in a handful of matches.
module tb_seq11_detect_scheduler;

    localparam int N     = 4;
    localparam int CH_W  = 2;
    localparam int CNT_W = 4;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    logic [1:0] held_ch;

    seq11_detect_scheduler_if #(.N(N), .CH_W(CH_W), .CNT_W(CNT_W)) bus ();

    seq11_detect_scheduler #(.N(N), .CH_W(CH_W), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [3:0] v, input logic [3:0] b,
                                 input logic [3:0] e, input logic [3:0] c);
        bus.bit_valid = v;
        bus.bit_in    = b;
        bus.ch_en     = e;
        bus.clr_ch    = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        applyStimulus(4'h0, 4'h0, 4'hF, 4'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        held_ch = 2'd0;
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        applyStimulus(4'hF, 4'hF, 4'hF, 4'h0);
        #3;
        checks++;
        if (bus.bit_ready !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b expected 0000", bus.bit_ready);
        end
        checks++;
        if (bus.match_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mv: got %b expected 0", bus.match_valid);
        end
        checks++;
        if (bus.match_ch !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_ch: got %0d expected 0", bus.match_ch);
        end
        checks++;
        if (bus.match_cnt !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_cnt: got %0d expected 0", bus.match_cnt);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.bit_ready !== 4'b0000 || bus.match_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_held: got ready %b mv %b expected 0000 0",
                     bus.bit_ready, bus.match_valid);
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (bus.bit_ready !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL reset_first_grant: got %b expected 0001", bus.bit_ready);
        end
        tick();
        checks++;
        if (bus.match_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_first_bit_mv: got %b expected 0", bus.match_valid);
        end
    endtask

    task automatic test_single_stream();
        logic bits [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic mv   [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b0001, {3'b000, bits[i]}, 4'hF, 4'h0);
            #1;
            checks++;
            if (bus.bit_ready !== 4'b0001) begin
                errors++;
                $display("[TB] FAIL single_ready[%0d]: got %b expected 0001", i, bus.bit_ready);
            end
            tick();
            if (mv[i]) held_ch = 2'd0;
            checks++;
            if (bus.match_valid !== mv[i]) begin
                errors++;
                $display("[TB] FAIL single_mv[%0d]: got %b expected %b", i, bus.match_valid, mv[i]);
            end
            checks++;
            if (bus.match_ch !== held_ch) begin
                errors++;
                $display("[TB] FAIL single_ch[%0d]: got %0d expected %0d", i, bus.match_ch, held_ch);
            end
        end
        applyStimulus(4'h0, 4'h0, 4'hF, 4'h0);
        checks++;
        if (bus.match_cnt !== 4'd2) begin
            errors++;
            $display("[TB] FAIL single_cnt: got %0d expected 2", bus.match_cnt);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_ready;
        logic       exp_mv;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'hF, 4'hF, 4'hF, 4'h0);
            #1;
            exp_ready = 4'b0001 << (i % 4);
            checks++;
            if (bus.bit_ready !== exp_ready) begin
                errors++;
                $display("[TB] FAIL rr_ready[%0d]: got %b expected %b", i, bus.bit_ready, exp_ready);
            end
            tick();
            exp_mv = (i >= 4);
            if (exp_mv) held_ch = 2'(i % 4);
            checks++;
            if (bus.match_valid !== exp_mv) begin
                errors++;
                $display("[TB] FAIL rr_mv[%0d]: got %b expected %b", i, bus.match_valid, exp_mv);
            end
            checks++;
            if (bus.match_ch !== held_ch) begin
                errors++;
                $display("[TB] FAIL rr_ch[%0d]: got %0d expected %0d", i, bus.match_ch, held_ch);
            end
        end
        applyStimulus(4'h0, 4'h0, 4'hF, 4'h0);
        checks++;
        if (bus.match_cnt !== 4'd4) begin
            errors++;
            $display("[TB] FAIL rr_cnt: got %0d expected 4", bus.match_cnt);
        end
    endtask

    task automatic test_interleave();
        logic [3:0] v   [3] = '{4'b0010, 4'b0110, 4'b0010};
        logic [3:0] b   [3] = '{4'b0010, 4'b0010, 4'b0010};
        logic [3:0] rdy [3] = '{4'b0010, 4'b0100, 4'b0010};
        logic       mv  [3] = '{1'b0, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(v[i], b[i], 4'hF, 4'h0);
            #1;
            checks++;
            if (bus.bit_ready !== rdy[i]) begin
                errors++;
                $display("[TB] FAIL inter_ready[%0d]: got %b expected %b", i, bus.bit_ready, rdy[i]);
            end
            tick();
            if (mv[i]) held_ch = 2'd1;
            checks++;
            if (bus.match_valid !== mv[i]) begin
                errors++;
                $display("[TB] FAIL inter_mv[%0d]: got %b expected %b", i, bus.match_valid, mv[i]);
            end
            checks++;
            if (bus.match_ch !== held_ch) begin
                errors++;
                $display("[TB] FAIL inter_ch[%0d]: got %0d expected %0d", i, bus.match_ch, held_ch);
            end
        end
        applyStimulus(4'h0, 4'h0, 4'hF, 4'h0);
    endtask

    task automatic test_clear();
        logic [3:0] clr [4] = '{4'b0000, 4'b1000, 4'b0000, 4'b0000};
        logic       mv  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'b1000, 4'b1000, 4'hF, clr[i]);
            #1;
            checks++;
            if (bus.bit_ready !== 4'b1000) begin
                errors++;
                $display("[TB] FAIL clr_ready[%0d]: got %b expected 1000", i, bus.bit_ready);
            end
            tick();
            if (mv[i]) held_ch = 2'd3;
            checks++;
            if (bus.match_valid !== mv[i]) begin
                errors++;
                $display("[TB] FAIL clr_mv[%0d]: got %b expected %b", i, bus.match_valid, mv[i]);
            end
            checks++;
            if (bus.match_ch !== held_ch) begin
                errors++;
                $display("[TB] FAIL clr_ch[%0d]: got %0d expected %0d", i, bus.match_ch, held_ch);
            end
        end
        applyStimulus(4'h0, 4'h0, 4'hF, 4'h0);
        checks++;
        if (bus.match_cnt !== 4'd1) begin
            errors++;
            $display("[TB] FAIL clr_cnt: got %0d expected 1", bus.match_cnt);
        end
    endtask

    task automatic test_disable();
        logic [3:0] v   [8] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'b0100, 4'b0100};
        logic [3:0] en  [8] = '{4'b1011, 4'b1011, 4'b1011, 4'b1011, 4'b1011, 4'b1011, 4'hF, 4'hF};
        logic [3:0] rdy [8] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000, 4'b0100, 4'b0100};
        logic       mv  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [1:0] ch  [8] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd3, 2'd3, 2'd2};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(v[i], 4'hF, en[i], 4'h0);
            #1;
            checks++;
            if (bus.bit_ready !== rdy[i]) begin
                errors++;
                $display("[TB] FAIL dis_ready[%0d]: got %b expected %b", i, bus.bit_ready, rdy[i]);
            end
            tick();
            checks++;
            if (bus.match_valid !== mv[i]) begin
                errors++;
                $display("[TB] FAIL dis_mv[%0d]: got %b expected %b", i, bus.match_valid, mv[i]);
            end
            checks++;
            if (bus.match_ch !== ch[i]) begin
                errors++;
                $display("[TB] FAIL dis_ch[%0d]: got %0d expected %0d", i, bus.match_ch, ch[i]);
            end
        end
        applyStimulus(4'h0, 4'h0, 4'hF, 4'h0);
    endtask

    task automatic test_saturation_and_reset();
        logic [3:0] exp_cnt;
        do_reset();
        for (int i = 0; i < 18; i++) begin
            applyStimulus(4'b0001, 4'b0001, 4'hF, 4'h0);
            #1;
            checks++;
            if (bus.bit_ready !== 4'b0001) begin
                errors++;
                $display("[TB] FAIL sat_ready[%0d]: got %b expected 0001", i, bus.bit_ready);
            end
            tick();
            exp_cnt = (i > 15) ? 4'd15 : 4'(i);
            checks++;
            if (bus.match_valid !== (i >= 1)) begin
                errors++;
                $display("[TB] FAIL sat_mv[%0d]: got %b expected %b", i, bus.match_valid, (i >= 1));
            end
            checks++;
            if (bus.match_cnt !== exp_cnt) begin
                errors++;
                $display("[TB] FAIL sat_cnt[%0d]: got %0d expected %0d", i, bus.match_cnt, exp_cnt);
            end
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.match_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_mv: got %b expected 0", bus.match_valid);
        end
        checks++;
        if (bus.match_cnt !== 4'd0) begin
            errors++;
            $display("[TB] FAIL async_cnt: got %0d expected 0", bus.match_cnt);
        end
        checks++;
        if (bus.match_ch !== 2'd0 || bus.bit_ready !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL async_ch_ready: got ch %0d ready %b expected 0 0000",
                     bus.match_ch, bus.bit_ready);
        end
        tick();
        applyStimulus(4'hF, 4'hF, 4'hF, 4'h0);
        reset_n = 1'b1;
        #1;
        checks++;
        if (bus.bit_ready !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL post_reset_grant: got %b expected 0001", bus.bit_ready);
        end
        tick();
        checks++;
        if (bus.match_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_ctx: got mv %b expected 0", bus.match_valid);
        end
        applyStimulus(4'h0, 4'h0, 4'hF, 4'h0);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        held_ch = 2'd0;
        test_reset();
        test_single_stream();
        test_round_robin();
        test_interleave();
        test_clear();
        test_disable();
        test_saturation_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
